fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage of the 16-bit LCA pipeline. It sits directly upstream of the first pipeline register (IF/ID) and drives that register's toPC, toPCInc and toIR inputs. It owns the PC, issues word requests to instruction memory over a req/ack handshake, and absorbs hazard-unit stalls with a 1-entry hold buffer. It also applies branch/jump redirects, including squashing any in-flight fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, encoding driven on toIR for a bubble

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hazard unit: freeze IF/ID inputs, no new fetch
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  16  target PC for redirect
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  word address of request
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
imem_rdata  input  16  instruction word
toPC  output  16  PC of delivered instruction
toPCInc  output  16  toPC + 1
toIR  output  16  delivered instruction or NOP_INSTR
fetch_valid  output  1  toIR holds a real instruction

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=IDLE, hold buffer empty, drop flag clear.
  - imem_req=0, imem_addr=RESET_PC, toPC=0, toPCInc=0, toIR=NOP_INSTR, fetch_valid=0.
  - Reset asserted mid-transaction abandons the request. Memory must tolerate a req drop on reset.
- States: IDLE, REQ, HOLD, DRAIN. All outputs are registered.
- IDLE:
  - Entered only after reset.
  - On the next edge go to REQ with imem_req=1 and imem_addr=pc.
- REQ:
  - imem_req=1. imem_addr stays stable until an edge with imem_ack=1. A request is never withdrawn without ack.
  - ack, no stall, no redirect: toPC<=pc, toPCInc<=pc+1, toIR<=imem_rdata, fetch_valid<=1, pc<=pc+1, imem_addr<=pc+1. Stay in REQ.
  - Throughput is 1 instruction/cycle with ack held high. Minimum latency is 1 cycle from req assertion to outputs.
  - no ack, no stall: toIR<=NOP_INSTR, fetch_valid<=0 (bubble).
  - ack with stall=1: imem_rdata, pc and pc+1 go into the hold buffer. Outputs are unchanged. pc<=pc+1, imem_req<=0, go HOLD.
  - stall=1, no ack: outputs unchanged. Keep requesting.
- HOLD:
  - imem_req=0 and outputs frozen while stall=1.
  - When stall=0: buffer drives the outputs with fetch_valid=1. Buffer empties. imem_req<=1 with imem_addr=pc. Go REQ.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_pc, toIR<=NOP_INSTR, fetch_valid<=0, hold buffer cleared. toPC/toPCInc hold their last values.
  - Request outstanding and not acked this cycle: go DRAIN (req and addr held).
  - Otherwise (ack this cycle, or in HOLD): the acked data is discarded. Next cycle imem_req=1 with imem_addr=redirect_pc, state REQ.
- DRAIN:
  - Keep req/addr until ack. The acked data is discarded, then request pc in REQ.
  - A further redirect in DRAIN only updates pc.
- Simultaneous stall+redirect: redirect wins; stall is ignored that cycle.
- Arithmetic: all PC math is 16-bit modulo. 16'hFFFF+1 = 16'h0000, with no flag.

Decomposition:
- Shared package lca_pkg:
  - WORD_W=16.
  - NOP_INSTR default.
  - RESET_PC default.
  - fetch-state enum {IDLE, REQ, HOLD, DRAIN}.
- One sub-module: fetch_hold_buffer.
  - 1-entry {pc, pcinc, instr} buffer with load/clear/full.
  - Reused later for the MEM-stage data skid.

Test Plan:
1. Reset low for 3 cycles, release; imem_ack tied 1, memory returns addr^16'hA5A5 -> toPC 0,1,2 on consecutive cycles from cycle 2; toIR = 16'hA5A5, 16'hA5A4, 16'hA5A7; fetch_valid=1 continuously.
2. imem_ack delayed 2 cycles per request -> fetch_valid pattern 0,0,1 repeating; imem_addr stable across the wait cycles; toPC increments by 1 per delivered instruction.
3. stall=1 in the same cycle as ack of addr 5 -> outputs stay at instruction 4, imem_req=0 for 3 stall cycles. On release, toPC=5 with the buffered instr and fetch_valid=1; the next request is addr 6.
4. redirect to 16'h0040 while the request for addr 9 is unacked -> fetch_valid=0; imem_addr stays 9 until ack, and that data never appears on toIR. Next request is 0x0040, then toPC=0x0040.
5. redirect and stall asserted together in HOLD -> buffer cleared, toIR=NOP_INSTR, fetch_valid=0, next request to redirect_pc.
6. RESET_PC=16'hFFFF, zero-wait memory -> first toPC=0xFFFF with toPCInc=0x0000, next toPC=0x0000.

Source files
------------

// File: rtl/lca_pkg.sv
// Shared types and defaults for the 16-bit LCA pipeline.
package lca_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC  = 16'h0000;
  localparam word_t DEFAULT_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } fetch_state_e;

  // One delivered instruction as seen by the IF/ID register.
  typedef struct packed {
    word_t pc;
    word_t pcinc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface fetch_stage_if;
  import lca_pkg::*;

  logic  req;
  word_t addr;
  logic  ack;
  word_t rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc, pcinc, instr} holding register with load/clear and a full flag.
module fetch_hold_buffer
  import lca_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t entry;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     full <= 1'b0;
    else if (clear) full <= 1'b0;
    else if (load)  full <= 1'b1;
  end

  // NOTE: the payload has no reset; it is only meaningful while full is set.
  always_ff @(posedge clk) begin
    if (load) entry <= din;
  end

  assign dout = entry;

endmodule

// File: rtl/fetch_stage.sv
// LCA instruction fetch: owns the PC, runs the imem handshake, absorbs stalls, applies redirects.
module fetch_stage
  import lca_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  word_t         redirect_pc,
  fetch_stage_if.master imem,
  output word_t         toPC,
  output word_t         toPCInc,
  output word_t         toIR,
  output logic          fetch_valid
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d, addr_q, addr_d;
  logic         req_q, req_d, valid_q, valid_d;
  fetch_entry_t out_q, out_d;

  logic         buf_load, buf_clear, buf_full;
  fetch_entry_t buf_in, buf_out;
  word_t        pc_inc;
  logic         ack;

  assign pc_inc = pc_q + word_t'(1);
  assign ack    = imem.ack & req_q;
  assign buf_in = '{pc: pc_q, pcinc: pc_inc, instr: imem.rdata};

  fetch_hold_buffer u_hold (
    .clk   (clk),
    .rst_n (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (buf_in),
    .dout  (buf_out),
    .full  (buf_full)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    valid_d   = valid_q;
    out_d     = out_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      REQ: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_d.instr = NOP_INSTR;
          valid_d     = 1'b0;
          buf_clear   = 1'b1;
          // An acked word is simply dropped; an unacked one must be drained first.
          if (ack) addr_d  = redirect_pc;
          else     state_d = DRAIN;
        end else if (ack && !stall) begin
          out_d   = buf_in;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          addr_d  = pc_inc;
        end else if (ack) begin
          buf_load = 1'b1;
          pc_d     = pc_inc;
          addr_d   = pc_inc;
          req_d    = 1'b0;
          state_d  = HOLD;
        end else if (!stall) begin
          out_d.instr = NOP_INSTR;
          valid_d     = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_d.instr = NOP_INSTR;
          valid_d     = 1'b0;
          buf_clear   = 1'b1;
          req_d       = 1'b1;
          addr_d      = redirect_pc;
          state_d     = REQ;
        end else if (!stall) begin
          if (buf_full) begin
            out_d   = buf_out;
            valid_d = 1'b1;
          end else begin
            out_d.instr = NOP_INSTR;
            valid_d     = 1'b0;
          end
          buf_clear = 1'b1;
          req_d     = 1'b1;
          addr_d    = pc_q;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (ack) begin
          addr_d  = pc_d;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '{pc: '0, pcinc: '0, instr: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = addr_q;
  assign toPC        = out_q.pc;
  assign toPCInc     = out_q.pcinc;
  assign toIR        = out_q.instr;
  assign fetch_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, stall/hold, redirects, PC wrap.
module tb_fetch_stage;
  import lca_pkg::*;

  logic  clk;
  logic  reset;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t to_pc, to_pc_inc, to_ir;
  logic  valid;
  word_t to_pc2, to_pc_inc2, to_ir2;
  logic  valid2;

  int checks = 0;
  int errors = 0;
  int lat;
  int wait_cnt;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .toPC        (to_pc),
    .toPCInc     (to_pc_inc),
    .toIR        (to_ir),
    .fetch_valid (valid)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .imem        (bus2),
    .toPC        (to_pc2),
    .toPCInc     (to_pc_inc2),
    .toIR        (to_ir2),
    .fetch_valid (valid2)
  );

  // Memory model: returns addr ^ A5A5, acking after lat wait cycles of a held request.
  assign bus.rdata  = bus.addr ^ 16'hA5A5;
  assign bus.ack    = bus.req && (wait_cnt >= lat);
  assign bus2.rdata = bus2.addr ^ 16'hA5A5;
  assign bus2.ack   = bus2.req;

  always @(posedge clk or negedge reset) begin
    if (!reset)                 wait_cnt <= 0;
    else if (bus.req && bus.ack) wait_cnt <= 0;
    else if (bus.req)           wait_cnt <= wait_cnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    word_t e;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; lat = 0;
    repeat (3) @(negedge clk);
    check("rst_req",   16'(bus.req), 16'h0);
    check("rst_addr",  bus.addr, 16'h0000);
    check("rst_pc",    to_pc, 16'h0000);
    check("rst_pcinc", to_pc_inc, 16'h0000);
    check("rst_ir",    to_ir, 16'h0000);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_addr2", bus2.addr, 16'hFFFF);
    reset = 1'b1;

    @(negedge clk);
    check("idle_req",   16'(bus.req), 16'h1);
    check("idle_addr",  bus.addr, 16'h0000);
    check("idle_valid", 16'(valid), 16'h0);

    // Zero-wait streaming, plus the wrapping instance alongside.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = word_t'(i);
      check("stream_pc",    to_pc, e);
      check("stream_pcinc", to_pc_inc, e + 16'h1);
      check("stream_ir",    to_ir, e ^ 16'hA5A5);
      check("stream_valid", 16'(valid), 16'h1);
      if (i == 0) begin
        check("wrap_pc0",    to_pc2, 16'hFFFF);
        check("wrap_pcinc0", to_pc_inc2, 16'h0000);
        check("wrap_ir0",    to_ir2, 16'h5A5A);
      end else if (i == 1) begin
        check("wrap_pc1",    to_pc2, 16'h0000);
        check("wrap_pcinc1", to_pc_inc2, 16'h0001);
        check("wrap_ir1",    to_ir2, 16'hA5A5);
      end
    end

    repeat (2) @(negedge clk);
    check("pre_stall_pc", to_pc, 16'h0004);
    check("pre_stall_addr", bus.addr, 16'h0005);

    // Stall lands on the ack of addr 5.
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_pc",    to_pc, 16'h0004);
      check("stall_ir",    to_ir, 16'hA5A1);
      check("stall_req",   16'(bus.req), 16'h0);
      check("stall_valid", 16'(valid), 16'h1);
    end
    stall = 1'b0;
    @(negedge clk);
    check("release_pc",    to_pc, 16'h0005);
    check("release_ir",    to_ir, 16'hA5A0);
    check("release_valid", 16'(valid), 16'h1);
    check("release_req",   16'(bus.req), 16'h1);
    check("release_addr",  bus.addr, 16'h0006);
    @(negedge clk);
    check("after_hold_pc", to_pc, 16'h0006);
    check("after_hold_ir", to_ir, 16'hA5A3);

    // Two wait states per request.
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        e = word_t'(7 + k);
        check("wait_valid", 16'(valid), (j == 2) ? 16'h1 : 16'h0);
        if (j < 2) check("wait_addr", bus.addr, e);
        else begin
          check("wait_pc", to_pc, e);
          check("wait_ir", to_ir, e ^ 16'hA5A5);
        end
      end
    end

    // Redirect while addr 9 is outstanding.
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_valid", 16'(valid), 16'h0);
    check("redir_ir",    to_ir, 16'h0000);
    check("redir_addr",  bus.addr, 16'h0009);
    check("redir_req",   16'(bus.req), 16'h1);
    check("redir_pc",    to_pc, 16'h0008);
    @(negedge clk);
    check("drain_addr",  bus.addr, 16'h0009);
    check("drain_valid", 16'(valid), 16'h0);
    @(negedge clk);
    check("drained_addr",  bus.addr, 16'h0040);
    check("drained_valid", 16'(valid), 16'h0);
    check("drained_ir",    to_ir, 16'h0000);
    lat = 0;
    @(negedge clk);
    check("target_pc",    to_pc, 16'h0040);
    check("target_pcinc", to_pc_inc, 16'h0041);
    check("target_ir",    to_ir, 16'hA5E5);
    check("target_valid", 16'(valid), 16'h1);

    // Enter HOLD, then stall and redirect together.
    stall = 1'b1;
    @(negedge clk);
    check("hold2_pc",  to_pc, 16'h0040);
    check("hold2_req", 16'(bus.req), 16'h0);
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    check("sr_valid", 16'(valid), 16'h0);
    check("sr_ir",    to_ir, 16'h0000);
    check("sr_req",   16'(bus.req), 16'h1);
    check("sr_addr",  bus.addr, 16'h0100);
    check("sr_pc",    to_pc, 16'h0040);
    @(negedge clk);
    check("sr_next_pc",    to_pc, 16'h0100);
    check("sr_next_ir",    to_ir, 16'hA4A5);
    check("sr_next_valid", 16'(valid), 16'h1);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    check("async_req",   16'(bus.req), 16'h0);
    check("async_valid", 16'(valid), 16'h0);
    check("async_pc",    to_pc, 16'h0000);
    check("async_addr",  bus.addr, 16'h0000);
    check("async_addr2", bus2.addr, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
